tile_pixel_fetch: RTL and testbench

//  Consumes the 6-bit in-tile pixel index from pixel_num, plus tile code and palette from VRAM/color RAM.

---
 rtl/video_pkg.sv | 19 +
 rtl/pipe_delay.sv | 28 ++
 rtl/tile_pixel_fetch.sv | 91 +++++++++
 tb/tb_tile_pixel_fetch.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and widths for the tile pixel fetch path.
// The sideband struct travels alongside the tile ROM read.
package video_pkg;

  localparam int TILE_W_DEF  = 8;
  localparam int PAL_W_DEF   = 5;
  localparam int TILE_ROM_AW = TILE_W_DEF + 4;
  localparam int PIX_IDX_W   = 6;

  typedef logic [1:0] pix2_t;

  typedef struct packed {
    logic                 valid;
    logic [PAL_W_DEF-1:0] pal;
    logic [1:0]           sel;
    logic                 blank;
  } fetch_sb_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with async reset, used to align
// pipeline sideband with the tile ROM read latency.
module pipe_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stages [DEPTH];

  // NOTE: every stage is reset, not just the head, so an in-flight
  // valid bit can never survive a reset and emerge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/tile_pixel_fetch.sv
// Tile pixel fetch: issues the tile ROM byte read for a pixel and
// extracts its 2bpp value into a palette PROM index.
module tile_pixel_fetch
  import video_pkg::*;
#(
  parameter int TILE_W  = TILE_W_DEF,
  parameter int PAL_W   = PAL_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [TILE_W-1:0]   in_tile,
  input  logic [PAL_W-1:0]    in_pal,
  input  logic [PIX_IDX_W-1:0] in_pixel_num,
  input  logic                in_blank,
  output logic                rom_en,
  output logic [TILE_W+3:0]   rom_addr,
  input  logic [7:0]          rom_data,
  output logic                out_valid,
  output logic [PAL_W+1:0]    out_color,
  output logic                out_transp,
  output logic                out_blank
);

  localparam int SB_W = $bits(fetch_sb_t);

  fetch_sb_t       sb_a;
  fetch_sb_t       sb_b;
  logic [SB_W-1:0] sb_b_bits;
  pix2_t           pix2;

  // Stage A: address and sideband capture. Payload holds across
  // gaps; valid and blank track the input every cycle.
  // NOTE: all state here uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
      sb_a     <= '0;
    end else begin
      rom_en     <= in_valid;
      sb_a.valid <= in_valid;
      sb_a.blank <= in_blank;
      if (in_valid) begin
        rom_addr <= {in_tile, in_pixel_num[5:2]};
        sb_a.pal <= in_pal;
        sb_a.sel <= in_pixel_num[1:0];
      end
    end
  end

  pipe_delay #(
    .W     (SB_W),
    .DEPTH (ROM_LAT)
  ) u_sb_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sb_a),
    .q     (sb_b_bits)
  );

  assign sb_b = fetch_sb_t'(sb_b_bits);

  // Low plane in bits 3:0, high plane in bits 7:4; index by {plane, sel}.
  assign pix2 = {rom_data[{1'b1, sb_b.sel}], rom_data[{1'b0, sb_b.sel}]};

  // Stage B: colour index; colour and transparency hold during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_color  <= '0;
      out_transp <= 1'b0;
      out_blank  <= 1'b0;
    end else begin
      out_valid <= sb_b.valid;
      out_blank <= sb_b.blank;
      if (sb_b.valid) begin
        if (sb_b.blank) begin
          out_color  <= '0;
          out_transp <= 1'b1;
        end else begin
          out_color  <= {sb_b.pal, pix2};
          out_transp <= (pix2 == 2'b00);
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Directed bench for tile_pixel_fetch at default parameters
// (ROM_LAT = 1), with a registered tile ROM model.
module tb_tile_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_tile;
  logic [4:0]  in_pal;
  logic [5:0]  in_pixel_num;
  logic        in_blank;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic [6:0]  out_color;
  logic        out_transp;
  logic        out_blank;

  logic [7:0]  rom_mem [4096];

  int n_checks = 0;
  int n_pass   = 0;

  // Streaming expectations for pixel_num 7..0 with byte 8'h5A.
  logic [1:0] stream_pix [8] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};

  always #5 clk = ~clk;

  tile_pixel_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_tile      (in_tile),
    .in_pal       (in_pal),
    .in_pixel_num (in_pixel_num),
    .in_blank     (in_blank),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .out_valid    (out_valid),
    .out_color    (out_color),
    .out_transp   (out_transp),
    .out_blank    (out_blank)
  );

  // Synchronous tile ROM, one cycle of read latency.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] tile, input logic [4:0] pal,
                       input logic [5:0] pn, input logic blank);
    in_valid     = v;
    in_tile      = tile;
    in_pal       = pal;
    in_pixel_num = pn;
    in_blank     = blank;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
    rom_data = 8'h00;
    rst_n    = 1'b0;
    drive(1'b1, 8'h41, 5'h09, 6'd15, 1'b0);

    // Reset held with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_color", out_color, 7'h00);
      check("rst_rom_en", rom_en, 1'b0);
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
    step();

    // Single pixel.
    rom_mem[12'h413] = 8'h88;
    drive(1'b1, 8'h41, 5'h09, 6'd15, 1'b0);
    step();
    check("single_rom_en", rom_en, 1'b1);
    check("single_rom_addr", rom_addr, 12'h413);
    drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
    step();
    check("single_not_early", out_valid, 1'b0);
    step();
    check("single_valid", out_valid, 1'b1);
    check("single_color", out_color, 7'h27);
    check("single_transp", out_transp, 1'b0);
    step();
    check("single_bubble", out_valid, 1'b0);
    check("single_hold", out_color, 7'h27);

    // Transparent pixel.
    rom_mem[12'h070] = 8'hEE;
    drive(1'b1, 8'h07, 5'h15, 6'd0, 1'b0);
    step();
    drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
    step();
    step();
    check("transp_valid", out_valid, 1'b1);
    check("transp_color", out_color, 7'h54);
    check("transp_flag", out_transp, 1'b1);
    step();

    // Streaming 8 back-to-back pixels.
    rom_mem[12'h5C1] = 8'h5A;
    rom_mem[12'h5C0] = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 8'h5C, 5'h11, 6'(7 - i), 1'b0);
      else       drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
      step();
      if (i >= 2) begin
        check("stream_valid", out_valid, 1'b1);
        check("stream_color", out_color, {5'h11, stream_pix[i-2]});
      end
    end
    step();
    check("stream_end", out_valid, 1'b0);

    // Bubble then blanked pixel.
    rom_mem[12'h101] = 8'h22;
    drive(1'b1, 8'h10, 5'h03, 6'd5, 1'b0);
    step();
    drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
    step();
    drive(1'b1, 8'h10, 5'h03, 6'd5, 1'b1);
    step();
    check("bb_v0", out_valid, 1'b1);
    check("bb_color0", out_color, 7'h0F);
    drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
    step();
    check("bb_v1", out_valid, 1'b0);
    step();
    check("bb_v2", out_valid, 1'b1);
    check("bb_color2", out_color, 7'h00);
    check("bb_transp2", out_transp, 1'b1);
    check("bb_blank2", out_blank, 1'b1);
    step();

    // Mid-stream reset with two pixels in flight.
    rom_mem[12'h200] = 8'hFF;
    drive(1'b1, 8'h20, 5'h1F, 6'd2, 1'b0);
    step();
    drive(1'b1, 8'h20, 5'h1F, 6'd3, 1'b0);
    step();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
    #1;
    check("mrst_valid_async", out_valid, 1'b0);
    check("mrst_rom_en_async", rom_en, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("mrst_drop0", out_valid, 1'b0);
    step();
    check("mrst_drop1", out_valid, 1'b0);

    rom_mem[12'h33F] = 8'h80;
    drive(1'b1, 8'h33, 5'h02, 6'd63, 1'b0);
    step();
    check("mrst_rom_addr", rom_addr, 12'h33F);
    drive(1'b0, 8'h00, 5'h00, 6'd0, 1'b0);
    step();
    check("mrst_not_early", out_valid, 1'b0);
    step();
    check("mrst_valid", out_valid, 1'b1);
    check("mrst_color", out_color, 7'h0A);
    check("mrst_transp", out_transp, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
